uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_pkg.sv | 42 ++++
 rtl/uart_tx_queue_byte_fifo.sv | 60 ++++++
 rtl/uart_tx_queue.sv | 139 +++++++++++++
 tb/tb_uart_tx_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared constants for the uart_tx_queue byte queue and its drain FSM.
// Holds uart register offsets, the STAT busy bit and FSM state codes.
`ifndef ADR_WIDTH
`define ADR_WIDTH 64
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

package uart_tx_queue_pkg;

    localparam int ADR_W = `ADR_WIDTH;
    localparam int DAT_W = `DAT_WIDTH;

    localparam logic [7:0] REG_STAT = 8'h00;
    localparam logic [7:0] REG_CTRL = 8'h08;
    localparam logic [7:0] REG_DATA = 8'h10;

    localparam int STAT_BUSY_BIT = 0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GAP       = 3'd1;
    localparam logic [2:0] ST_POLL      = 3'd2;
    localparam logic [2:0] ST_POLL_END  = 3'd3;
    localparam logic [2:0] ST_WRITE     = 3'd4;
    localparam logic [2:0] ST_WRITE_END = 3'd5;

    typedef struct packed {
        logic             stb;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    function automatic logic [ADR_W-1:0] reg_adr(
        input logic [63:0] base,
        input logic [7:0]  off
    );
        return ADR_W'(base + {56'h0, off});
    endfunction

endpackage

// File: rtl/uart_tx_queue_byte_fifo.sv
// byte_fifo: circular byte buffer with count-based full/empty.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == LW'(DEPTH));
    assign empty_o = (count == '0);
    assign level_o = count;
    assign head_o  = mem[rptr];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue drained to a Wishbone uart via STAT polling.
// Define UART_TXQ_STATS_EN to add the saturating drop_cnt_o counter.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [63:0] UART_BASE = 64'h0,
    parameter int          POLL_GAP  = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [7:0]            byte_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LW-1:0]         level_o,
    output logic                  err_o,
    output logic [`ADR_WIDTH-1:0] m_adr_o,
    output logic [`DAT_WIDTH-1:0] m_dat_o,
    input  logic [`DAT_WIDTH-1:0] m_dat_i,
    output logic                  m_we_o,
    output logic                  m_stb_o,
    input  logic                  m_ack_i,
    input  logic                  m_err_i
`ifdef UART_TXQ_STATS_EN
    ,
    output logic [15:0]           drop_cnt_o
`endif
);

    localparam int GW = $clog2(POLL_GAP + 1) + 1;
    localparam logic [ADR_W-1:0] ADR_STAT = reg_adr(UART_BASE, REG_STAT);
    localparam logic [ADR_W-1:0] ADR_DATA = reg_adr(UART_BASE, REG_DATA);

    logic [2:0]    state;
    logic          busy;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    head;
    logic          bus_done;
    logic          pop;
    logic          unused_dat;
    wb_req_t       req;

    assign bus_done   = m_ack_i | m_err_i;
    assign pop        = (state == ST_WRITE) & bus_done;
    assign unused_dat = ^m_dat_i;

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_i),
        .data_i (byte_i),
        .pop_i  (pop),
        .head_o (head),
        .full_o (full_o),
        .empty_o(empty_o),
        .level_o(level_o)
    );

    // GAP falls back to IDLE once drained so no poll hits an empty queue
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
            err_o   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty_o) state <= ST_POLL;
                end
                ST_POLL: begin
                    if (m_ack_i) begin
                        busy  <= m_dat_i[STAT_BUSY_BIT];
                        state <= ST_POLL_END;
                    end else if (m_err_i) begin
                        err_o   <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_POLL_END: begin
                    gap_cnt <= '0;
                    state   <= busy ? ST_GAP : ST_WRITE;
                end
                ST_GAP: begin
                    if (int'(gap_cnt) + 1 >= POLL_GAP) begin
                        state <= empty_o ? ST_IDLE : ST_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bus_done) begin
                        if (!m_ack_i) err_o <= 1'b1;
                        state <= ST_WRITE_END;
                    end
                end
                ST_WRITE_END: begin
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req = '0;
        if (state == ST_POLL) begin
            req.stb = 1'b1;
            req.adr = ADR_STAT;
        end else if (state == ST_WRITE) begin
            req.stb = 1'b1;
            req.we  = 1'b1;
            req.adr = ADR_DATA;
            req.dat = DAT_W'(head);
        end
    end

    assign m_stb_o = req.stb;
    assign m_we_o  = req.we;
    assign m_adr_o = req.adr;
    assign m_dat_o = req.dat;

`ifdef UART_TXQ_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (push_i && full_o && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a queue-based model.
// Covers UART_TXQ_STATS_EN builds when that macro is defined.
module tb_uart_tx_queue;

    localparam int          DEPTH    = 8;
    localparam int          POLL_GAP = 3;
    localparam logic [63:0] BASE     = 64'h0000_0000_1000_0000;
    localparam int          LW       = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst_i;
    logic                  push_i;
    logic [7:0]            byte_i;
    logic                  full;
    logic                  empty;
    logic [LW-1:0]         level;
    logic                  err;
    logic [`ADR_WIDTH-1:0] adr;
    logic [`DAT_WIDTH-1:0] dat_o;
    logic [`DAT_WIDTH-1:0] dat_i;
    logic                  we;
    logic                  stb;
    logic                  ack;
    logic                  serr;
`ifdef UART_TXQ_STATS_EN
    logic [15:0]           drop_cnt;
`endif

    uart_tx_queue #(
        .DEPTH    (DEPTH),
        .UART_BASE(BASE),
        .POLL_GAP (POLL_GAP)
    ) dut (
`ifdef UART_TXQ_STATS_EN
        .drop_cnt_o(drop_cnt),
`endif
        .clk_i  (clk),
        .rst_i  (rst_i),
        .push_i (push_i),
        .byte_i (byte_i),
        .full_o (full),
        .empty_o(empty),
        .level_o(level),
        .err_o  (err),
        .m_adr_o(adr),
        .m_dat_o(dat_o),
        .m_dat_i(dat_i),
        .m_we_o (we),
        .m_stb_o(stb),
        .m_ack_i(ack),
        .m_err_i(serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic [7:0] wlog[$];
    int  mdrops = 0;
    bit  merr = 0;
    int  busy_left = 0;
    bit  err_wr = 0;
    bit  err_rd = 0;
    bit  hold_wr = 0;
    bit  rnd_mode = 0;
    int  lat = 0;
    int  wcnt = 0;
    int  reads = 0;
    int  writes = 0;
    bit  prev_stb = 0;
    bit  prev_resp = 0;
    int  idle_run = 0;
    int  last_op = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: check outputs, play the slave, advance the model
    task automatic step(input bit p, input logic [7:0] b, input bit r);
        bit resp;
        bit do_pop;
        bit was_full;
        resp   = 0;
        do_pop = 0;
        chk("level", 64'(level), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("err", 64'(err), 64'(merr));
`ifdef UART_TXQ_STATS_EN
        chk("drops", 64'(drop_cnt), 64'(mdrops));
`endif
        if (!stb) chk("we_idle", 64'(we), 64'(0));
        if (prev_resp) chk("stb_gap", 64'(stb), 64'(0));
        if (stb && !prev_stb && !we) begin
            if (last_op == 1)
                chk("poll_gap", 64'(idle_run), 64'(POLL_GAP + 1));
            else if (last_op == 2)
                chk("err_gap", 64'(idle_run), 64'(POLL_GAP));
        end
        idle_run = stb ? 0 : idle_run + 1;
        ack   = 1'b0;
        serr  = 1'b0;
        dat_i = '0;
        if (stb && !r && !(hold_wr && we)) begin
            if (wcnt < lat) begin
                wcnt++;
            end else begin
                resp = 1;
                wcnt = 0;
                lat  = rnd_mode ? $urandom_range(0, 2) : 0;
                if (!we) begin
                    chk("rd_adr", 64'(adr), BASE + 64'h00);
                    reads++;
                    if (err_rd) begin
                        serr    = 1'b1;
                        err_rd  = 0;
                        merr    = 1;
                        last_op = 2;
                    end else begin
                        ack      = 1'b1;
                        dat_i    = {$urandom(), $urandom()};
                        dat_i[0] = (busy_left > 0);
                        last_op  = (busy_left > 0) ? 1 : 3;
                        if (busy_left > 0) busy_left--;
                    end
                end else begin
                    chk("wr_adr", 64'(adr), BASE + 64'h10);
                    chk("wr_nonempty", 64'(empty), 64'(0));
                    if (q.size() > 0)
                        chk("wr_dat", 64'(dat_o), {56'h0, q[0]});
                    writes++;
                    do_pop  = 1;
                    last_op = 3;
                    if (err_wr) begin
                        serr   = 1'b1;
                        err_wr = 0;
                        merr   = 1;
                    end else begin
                        ack = 1'b1;
                        wlog.push_back(dat_o[7:0]);
                    end
                end
            end
        end
        prev_resp = resp;
        prev_stb  = stb;
        if (r) begin
            q.delete();
            mdrops    = 0;
            merr      = 0;
            last_op   = 0;
            prev_resp = 0;
            prev_stb  = 0;
            idle_run  = 0;
            wcnt      = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (do_pop && q.size() > 0) void'(q.pop_front());
            if (p) begin
                if (was_full) begin
                    if (mdrops < 65535) mdrops++;
                end else begin
                    q.push_back(b);
                end
            end
        end
        rst_i  = r;
        push_i = p;
        byte_i = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 8'h00, 0);
    endtask

    task automatic do_reset();
        step(0, 8'h00, 1);
        chk("rst_stb", 64'(stb), 64'(0));
        step(0, 8'h00, 0);
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (writes < n && k < budget) begin
            step(0, 8'h00, 0);
            k++;
        end
        chk("wr_timeout", 64'(writes >= n), 64'(1));
    endtask

    initial begin
        int act;
        int k;
        rst_i  = 1'b1;
        push_i = 1'b0;
        byte_i = 8'h00;
        ack    = 1'b0;
        serr   = 1'b0;
        dat_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        do_reset();

        // single byte, uart idle
        reads = 0; writes = 0; wlog.delete();
        step(1, 8'h41, 0);
        chk("t1_level", 64'(level), 64'(1));
        run_until(1, 100);
        idle(20);
        chk("t1_reads", 64'(reads), 64'(1));
        chk("t1_byte", 64'(wlog[0]), 64'h41);

        // three busy polls before the write
        reads = 0; writes = 0; wlog.delete();
        busy_left = 3;
        step(1, 8'h55, 0);
        run_until(1, 200);
        idle(10);
        chk("t2_reads", 64'(reads), 64'(4));
        chk("t2_byte", 64'(wlog[0]), 64'h55);

        // overfill while uart reports busy
        do_reset();
        busy_left = 100000;
        for (int i = 0; i < DEPTH + 2; i++) step(1, 8'(i), 0);
        step(0, 8'h00, 0);
        chk("t3_full", 64'(full), 64'(1));
`ifdef UART_TXQ_STATS_EN
        chk("t3_drops", 64'(drop_cnt), 64'(2));
`endif
        busy_left = 0; writes = 0; wlog.delete();
        run_until(DEPTH, 2000);
        for (int i = 0; i < DEPTH; i++)
            chk("t3_order", 64'(wlog[i]), 64'(i));

        // write answered with a bus error
        idle(10);
        writes = 0; wlog.delete();
        err_wr = 1;
        step(1, 8'hA5, 0);
        step(1, 8'h3C, 0);
        run_until(2, 400);
        idle(10);
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_sent", 64'(wlog.size()), 64'(1));
        chk("t4_byte", 64'(wlog[0]), 64'h3C);

        // reset while a write is on the bus
        do_reset();
        hold_wr = 1;
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
        k = 0;
        while (!(stb && we) && k < 50) begin
            step(0, 8'h00, 0);
            k++;
        end
        chk("t5_inwrite", 64'(stb && we), 64'(1));
        chk("t5_level", 64'(level), 64'(5));
        step(0, 8'h00, 1);
        hold_wr = 0;
        chk("t5_stb", 64'(stb), 64'(0));
        chk("t5_lvl0", 64'(level), 64'(0));
        chk("t5_empty", 64'(empty), 64'(1));
        act = 0;
        for (int i = 0; i < 30; i++) begin
            act += int'(stb);
            step(0, 8'h00, 0);
        end
        chk("t5_quiet", 64'(act), 64'(0));

        // random traffic
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) err_wr = 1;
            if ($urandom_range(0, 15) == 0) err_rd = 1;
            if ($urandom_range(0, 7) == 0) busy_left = $urandom_range(0, 2);
            step($urandom_range(0, 2) == 0, 8'($urandom()), 0);
        end
        k = 0;
        while (q.size() > 0 && k < 4000) begin
            step(0, 8'h00, 0);
            k++;
        end
        idle(20);
        chk("drain_empty", 64'(empty), 64'(1));
        chk("drain_stb", 64'(stb), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
